// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: host handshakes, job control and PE-array edge signals of the systolic feeder
interface systolic_feeder_if #(
    parameter int DATA_SIZE = 32,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
);
    logic                      start;
    logic [15:0]               num_vec;
    logic                      busy;
    logic                      done;
    logic                      w_valid;
    logic                      w_ready;
    logic [COLS*DATA_SIZE-1:0] w_data;
    logic                      a_valid;
    logic                      a_ready;
    logic [ROWS*DATA_SIZE-1:0] a_data;
    logic [ROWS-1:0]           arr_enable;
    logic [ROWS-1:0]           arr_ld_weight;
    logic [COLS*DATA_SIZE-1:0] arr_sum_top;
    logic [ROWS*DATA_SIZE-1:0] arr_data_left;
    logic                      vec_issued;

    modport master (
        output start, num_vec, w_valid, w_data, a_valid, a_data,
        input  busy, done, w_ready, a_ready, arr_enable, arr_ld_weight, arr_sum_top, arr_data_left, vec_issued
    );
    modport slave (
        input  start, num_vec, w_valid, w_data, a_valid, a_data,
        output busy, done, w_ready, a_ready, arr_enable, arr_ld_weight, arr_sum_top, arr_data_left, vec_issued
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers weights, bursts them down the columns, then streams row-skewed activations; SYSTOLIC_FEEDER_WREUSE_EN adds keep_weights
module systolic_feeder #(
    parameter int DATA_SIZE  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int PE_LATENCY = 4
) (
    input logic clk,
    input logic reset,
    systolic_feeder_if.slave f
`ifdef SYSTOLIC_FEEDER_WREUSE_EN
    , input logic keep_weights
`endif
);
    localparam int DRAIN_LEN = (ROWS - 1) + PE_LATENCY * (ROWS + COLS);
    localparam int WW = COLS * DATA_SIZE;
    localparam int IW = $clog2(ROWS);

    typedef enum logic [2:0] {IDLE, W_FILL, W_LOAD, STREAM, DRAIN, DONE} state_t;

    state_t              state, nxt;
    logic [31:0]         cnt, cnt_nxt;
    logic [15:0]         nv;
    logic [ROWS-1:0][WW-1:0] wbuf;
    logic [IW-1:0]       rd_idx;
    logic [WW-1:0]       load_row;
    logic                accept;
    logic                reuse;
    logic [ROWS-1:0][DATA_SIZE-1:0] left;

`ifdef SYSTOLIC_FEEDER_WREUSE_EN
    assign reuse = keep_weights;
`else
    assign reuse = 1'b0;
`endif

    assign f.busy    = state != IDLE;
    assign f.done    = state == DONE;
    assign f.w_ready = state == W_FILL;
    assign f.a_ready = state == STREAM;
    assign accept    = f.a_ready && f.a_valid;

    // The burst's first row is the beat being accepted; later rows come from the buffer
    assign rd_idx   = (state == W_LOAD && cnt < 32'(ROWS - 1)) ? IW'(32'(ROWS - 2) - cnt) : '0;
    assign load_row = state == W_LOAD ? wbuf[rd_idx] : f.w_data;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (f.start) begin
                nxt     = reuse ? (f.num_vec == 16'd0 ? DRAIN : STREAM) : W_FILL;
                cnt_nxt = '0;
            end
            W_FILL: if (f.w_valid) begin
                cnt_nxt = cnt == 32'(ROWS - 1) ? '0 : cnt + 1;
                nxt     = cnt == 32'(ROWS - 1) ? W_LOAD : W_FILL;
            end
            W_LOAD: begin
                cnt_nxt = cnt == 32'(ROWS - 1) ? '0 : cnt + 1;
                nxt     = cnt == 32'(ROWS - 1) ? (nv == 16'd0 ? DRAIN : STREAM) : W_LOAD;
            end
            STREAM: if (f.a_valid) begin
                cnt_nxt = cnt + 1 == {16'd0, nv} ? '0 : cnt + 1;
                nxt     = cnt + 1 == {16'd0, nv} ? DRAIN : STREAM;
            end
            DRAIN: begin
                cnt_nxt = cnt == 32'(DRAIN_LEN - 1) ? '0 : cnt + 1;
                nxt     = cnt == 32'(DRAIN_LEN - 1) ? DONE : DRAIN;
            end
            DONE: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            nv              <= '0;
            f.arr_enable    <= '0;
            f.arr_ld_weight <= '0;
            f.arr_sum_top   <= '0;
            f.vec_issued    <= 1'b0;
        end else begin
            state           <= nxt;
            cnt             <= cnt_nxt;
            if (state == IDLE && f.start) nv <= f.num_vec;
            if (state == W_FILL && f.w_valid) wbuf[cnt[IW-1:0]] <= f.w_data;
            f.arr_enable    <= (nxt == IDLE || nxt == W_FILL) ? '0 : '1;
            f.arr_ld_weight <= nxt == W_LOAD ? '1 : '0;
            f.arr_sum_top   <= nxt == W_LOAD ? load_row : '0;
            f.vec_issued    <= accept;
        end
    end

    // Row r sees the issued slice after r+1 register stages
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_SIZE-1:0] sr [0:r];
        always_ff @(posedge clk) begin
            if (reset) sr <= '{default: '0};
            else begin
                sr[0] <= accept ? f.a_data[r*DATA_SIZE +: DATA_SIZE] : '0;
                for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
            end
        end
        assign left[r] = sr[r];
    end

    assign f.arr_data_left = left;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed vectors against hand-computed values for a 4x4 feeder
module tb_systolic_feeder;
    localparam int DS = 32, R = 4, C = 4;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    systolic_feeder_if #(.DATA_SIZE(DS), .ROWS(R), .COLS(C)) f();
`ifdef SYSTOLIC_FEEDER_WREUSE_EN
    logic keep_weights = 0;
`endif

    systolic_feeder #(.DATA_SIZE(DS), .ROWS(R), .COLS(C), .PE_LATENCY(4)) dut (
        .clk(clk),
        .reset(reset),
        .f(f)
`ifdef SYSTOLIC_FEEDER_WREUSE_EN
        , .keep_weights(keep_weights)
`endif
    );

    int n_vec = 0, n_err = 0, vi_cnt = 0, ld_cnt = 0, done_cnt = 0, n = 0, d0 = 0;
    logic [127:0] pe_w [0:3];
    logic [127:0] exp_b [0:2];

    // Column-shift model of the PE weight registers
    always @(posedge clk) begin
        if (f.arr_ld_weight[0]) pe_w[0] <= f.arr_sum_top;
        for (int r = 1; r < R; r++) if (f.arr_ld_weight[r]) pe_w[r] <= pe_w[r-1];
    end

    function automatic logic [127:0] wrow(input int k);
        logic [127:0] v;
        for (int c = 0; c < C; c++) v[c*32 +: 32] = 32'(k * 16 + c);
        return v;
    endfunction

    function automatic logic [127:0] v4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (f.vec_issued) vi_cnt++;
        if (|f.arr_ld_weight) ld_cnt++;
        if (f.done) done_cnt++;
    endtask

    task automatic begin_job(input int nv);
        f.start = 1;
        f.num_vec = 16'(nv);
        step();
        f.start = 0;
        check("busy", f.busy, 1);
    endtask

    task automatic load(input bit gapped);
        check("w_ready", f.w_ready, 1);
        check("fill_en", f.arr_enable, 0);
        for (int k = 0; k < 4; k++) begin
            if (gapped) begin
                f.w_valid = 0;
                repeat (k + 1) begin
                    step();
                    check("gap_ld", f.arr_ld_weight, 0);
                end
            end
            f.w_valid = 1;
            f.w_data = wrow(k);
            step();
            if (k < 3) check("fill_ld", f.arr_ld_weight, 0);
        end
        f.w_valid = 0;
        check("ld_first", f.arr_ld_weight, 4'hF);
        check("sum_row3", f.arr_sum_top, wrow(3));
        for (int i = 1; i < 4; i++) begin
            step();
            check("ld_burst", f.arr_ld_weight, 4'hF);
            check("sum_row", f.arr_sum_top, wrow(3 - i));
            check("load_en", f.arr_enable, 4'hF);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!f.done && cycles < 200) begin
            step();
            cycles++;
        end
        check("done_seen", f.done, 1);
        step();
        check("idle_busy", f.busy, 0);
        check("idle_en", f.arr_enable, 0);
    endtask

    initial begin
        f.start = 0; f.num_vec = 0; f.w_valid = 0; f.w_data = 0; f.a_valid = 0; f.a_data = 0;
        repeat (2) step();
        check("rst_ctl", {f.busy, f.done, f.w_ready, f.a_ready, f.vec_issued}, 0);
        check("rst_en", {f.arr_enable, f.arr_ld_weight}, 0);
        check("rst_sum", f.arr_sum_top, 0);
        check("rst_left", f.arr_data_left, 0);
        reset = 0;
        step();

        // Weights only: burst, drain length, resulting PE weights
        begin_job(0);
        load(0);
        step();
        check("drain_ld", f.arr_ld_weight, 0);
        check("drain_sum", f.arr_sum_top, 0);
        check("drain_en", f.arr_enable, 4'hF);
        wait_done(n);
        check("drain_len", n, 35);
        for (int r = 0; r < R; r++) check("pe_weight", pe_w[r], wrow(r));

        // Gapped weight fill, then two back-to-back vectors
        vi_cnt = 0;
        begin_job(2);
        load(1);
        step();
        check("a_ready", f.a_ready, 1);
        f.a_valid = 1; f.a_data = v4(1, 2, 3, 4);
        step();
        check("skew_t1", f.arr_data_left, v4(1, 0, 0, 0));
        check("vi_t1", f.vec_issued, 1);
        f.a_data = v4(5, 6, 7, 8);
        step();
        check("skew_t2", f.arr_data_left, v4(5, 2, 0, 0));
        check("vi_t2", f.vec_issued, 1);
        check("a_ready_drop", f.a_ready, 0);
        f.a_valid = 0;
        step(); check("skew_t3", f.arr_data_left, v4(0, 6, 3, 0));
        step(); check("skew_t4", f.arr_data_left, v4(0, 0, 7, 4));
        step(); check("skew_t5", f.arr_data_left, v4(0, 0, 0, 8));
        step(); check("skew_t6", f.arr_data_left, 0);
        wait_done(n);
        check("vi_count2", vi_cnt, 2);

        // Bubbles mid-stream
        vi_cnt = 0;
        exp_b[0] = v4(0, 10, 0, 0); exp_b[1] = v4(0, 0, 11, 0); exp_b[2] = v4(0, 0, 0, 12);
        begin_job(3);
        load(0);
        step();
        f.a_valid = 1; f.a_data = v4(9, 10, 11, 12);
        step();
        check("b_first", f.arr_data_left, v4(9, 0, 0, 0));
        f.a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bubble_vi", f.vec_issued, 0);
            check("bubble_left", f.arr_data_left, exp_b[i]);
            check("bubble_ready", f.a_ready, 1);
        end
        f.a_valid = 1; f.a_data = v4(13, 14, 15, 16);
        step();
        check("b_second", f.arr_data_left, v4(13, 0, 0, 0));
        f.a_data = v4(17, 18, 19, 20);
        step();
        check("b_ready_drop", f.a_ready, 0);
        f.a_valid = 0;
        wait_done(n);
        check("vi_count3", vi_cnt, 3);

        // Reset during STREAM, then a clean job
        begin_job(5);
        load(0);
        step();
        f.a_valid = 1; f.a_data = v4(1, 1, 1, 1);
        step(); step();
        f.a_valid = 0;
        reset = 1;
        step();
        reset = 0;
        check("mid_rst_ctl", {f.busy, f.done, f.a_ready, f.vec_issued}, 0);
        check("mid_rst_en", {f.arr_enable, f.arr_ld_weight}, 0);
        check("mid_rst_left", f.arr_data_left, 0);
        d0 = done_cnt;
        repeat (5) step();
        check("no_done", done_cnt - d0, 0);
        vi_cnt = 0;
        begin_job(1);
        load(0);
        step();
        f.a_valid = 1; f.a_data = v4(21, 22, 23, 24);
        step();
        check("clean_t1", f.arr_data_left, v4(21, 0, 0, 0));
        f.a_valid = 0;
        step();
        check("clean_t2", f.arr_data_left, v4(0, 22, 0, 0));
        wait_done(n);
        check("vi_count1", vi_cnt, 1);

`ifdef SYSTOLIC_FEEDER_WREUSE_EN
        // Weight reuse: no fill, no burst
        ld_cnt = 0;
        keep_weights = 1;
        begin_job(1);
        keep_weights = 0;
        check("reuse_wready", f.w_ready, 0);
        check("reuse_aready", f.a_ready, 1);
        f.a_valid = 1; f.a_data = v4(7, 7, 7, 7);
        step();
        f.a_valid = 0;
        wait_done(n);
        check("reuse_ld", ld_cnt, 0);
        for (int r = 0; r < R; r++) check("reuse_pe", pe_w[r], wrow(r));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
